// File: rtl/morse_key_decoder.sv
// Morse key receiver: times presses of one key, classifies dot/dash, and
// assembles up to four symbols MSB-first into a code/length pair, decoding
// letters A..H. A letter ends after three silent time units.
module morse_key_decoder #(
  parameter int unsigned UNIT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key,
  output logic [3:0] code,
  output logic [2:0] len,
  output logic [2:0] letter,
  output logic       hit,
  output logic       valid,
  output logic       err
);

  localparam int unsigned CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic             key_meta_r;
  logic             key_s;
  logic             key_d_r;
  logic [CYC_W-1:0] cyc_r;
  logic [2:0]       units_r;
  logic [3:0]       sr_r;
  logic [2:0]       n_r;
  logic             ovf_r;

  logic             rise_s;
  logic             fall_s;
  logic             wrap_s;
  logic [2:0]       units_nx_s;
  logic             dash_s;

  // Table lookup: returns {hit, letter}; unmatched patterns give all zeros.
  function automatic logic [3:0] decode(input logic [3:0] c, input logic [2:0] l);
    logic [3:0] r;
    case ({l, c})
      7'b010_0100: r = 4'b1_000;  // A
      7'b100_1000: r = 4'b1_001;  // B
      7'b100_1010: r = 4'b1_010;  // C
      7'b011_1000: r = 4'b1_011;  // D
      7'b001_0000: r = 4'b1_100;  // E
      7'b100_0010: r = 4'b1_101;  // F
      7'b011_1100: r = 4'b1_110;  // G
      7'b100_0000: r = 4'b1_111;  // H
      default:     r = 4'b0_000;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_r <= 1'b0;
      key_s      <= 1'b0;
      key_d_r    <= 1'b0;
    end else begin
      key_meta_r <= key;
      key_s      <= key_meta_r;
      key_d_r    <= key_s;
    end
  end

  assign rise_s = key_s & ~key_d_r;
  assign fall_s = ~key_s & key_d_r;
  assign wrap_s = (cyc_r == CYC_LAST);
  // Unit count as it stands after this cycle; lets classification and letter
  // end take effect on the very edge the threshold is crossed.
  assign units_nx_s = (wrap_s && (units_r != 3'd7)) ? (units_r + 3'd1) : units_r;
  assign dash_s     = (units_nx_s >= 3'd2);

  // Timebase: cycle counter within a unit and saturating unit counter,
  // both restarted on every key edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_r   <= '0;
      units_r <= 3'd0;
    end else if (rise_s || fall_s) begin
      cyc_r   <= '0;
      units_r <= 3'd0;
    end else begin
      cyc_r   <= wrap_s ? '0 : (cyc_r + {{(CYC_W-1){1'b0}}, 1'b1});
      units_r <= units_nx_s;
    end
  end

  // Letter FSM: collects symbols, ends letters on a long gap, drives outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      sr_r    <= 4'd0;
      n_r     <= 3'd0;
      ovf_r   <= 1'b0;
      code    <= 4'd0;
      len     <= 3'd0;
      letter  <= 3'd0;
      hit     <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= PRESS;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS: begin
          if (fall_s) begin
            state_r <= GAP;
            if (n_r < 3'd4) begin
              sr_r <= sr_r | ({dash_s, 3'b000} >> n_r);
              n_r  <= n_r + 3'd1;
            end else begin
              ovf_r <= 1'b1;
            end
          end else begin
            state_r <= PRESS;
          end
        end
        GAP: begin
          if (units_nx_s == 3'd3) begin
            if (ovf_r) begin
              err <= 1'b1;
            end else begin
              valid         <= 1'b1;
              code          <= sr_r;
              len           <= n_r;
              {hit, letter} <= decode(sr_r, n_r);
            end
            sr_r    <= 4'd0;
            n_r     <= 3'd0;
            ovf_r   <= 1'b0;
            // A press landing on the ending edge starts the next letter.
            state_r <= rise_s ? PRESS : IDLE;
          end else if (rise_s) begin
            state_r <= PRESS;
          end else begin
            state_r <= GAP;
          end
        end
        default: begin
          state_r <= IDLE;
          sr_r    <= 4'd0;
          n_r     <= 3'd0;
          ovf_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with UNIT_CYCLES = 4.
module tb_morse_key_decoder;

  localparam int unsigned U = 4;

  logic       clk;
  logic       reset_n;
  logic       key;
  logic [3:0] code;
  logic [2:0] len;
  logic [2:0] letter;
  logic       hit;
  logic       valid;
  logic       err;

  int checks;
  int errors;
  int vcnt;
  int ecnt;
  int cyc_tb;
  int v_cyc;

  morse_key_decoder #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .reset_n(reset_n), .key(key),
    .code(code), .len(len), .letter(letter), .hit(hit),
    .valid(valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_tb++;

  // Pulse monitor: counts every cycle each pulse is high.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++;
      v_cyc = cyc_tb;
    end
    if (err === 1'b1) ecnt++;
  end

  // Hold key at lvl for n sampling edges; starts and ends 1 time unit after a posedge.
  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    vcnt = 0;
    ecnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({code, len, letter, hit, valid, err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {code, len, letter, hit, valid, err});
    end
    clear_counts();
    reset_n = 1'b1;
    hold(1'b1, 4);
    hold(1'b0, 20);
    checks++;
    if (vcnt !== 1) begin errors++; $display("FAIL reset_press_valid_count: got %0d expected 1", vcnt); end
    checks++;
    if ({code, len, letter, hit} !== {4'b0000, 3'd1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL reset_press_E: got code=%b len=%0d letter=%0d hit=%b expected 0000/1/4/1", code, len, letter, hit);
    end
  endtask

  task automatic test_letter_a();
    int t_drop;
    clear_counts();
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 12);
    t_drop = cyc_tb;
    hold(1'b0, 16);
    checks++;
    if (vcnt !== 1) begin errors++; $display("FAIL a_valid_count: got %0d expected 1", vcnt); end
    checks++;
    if ({code, len, letter, hit} !== {4'b0100, 3'd2, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL a_decode: got code=%b len=%0d letter=%0d hit=%b expected 0100/2/0/1", code, len, letter, hit);
    end
    checks++;
    if (v_cyc - t_drop !== 15) begin
      errors++;
      $display("FAIL a_valid_latency: got %0d expected 15", v_cyc - t_drop);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 4);
      hold(1'b0, (i < 4) ? 4 : 16);
    end
    checks++;
    if (ecnt !== 1) begin errors++; $display("FAIL ovf_err_count: got %0d expected 1", ecnt); end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL ovf_valid_count: got %0d expected 0", vcnt); end
    checks++;
    if ({code, len, letter, hit} !== {4'b0100, 3'd2, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_hold: got code=%b len=%0d letter=%0d hit=%b expected 0100/2/0/1", code, len, letter, hit);
    end
  endtask

  task automatic test_threshold();
    clear_counts();
    hold(1'b1, 7);
    hold(1'b0, 16);
    checks++;
    if ({vcnt[3:0], code, len, letter, hit} !== {4'd1, 4'b0000, 3'd1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL thr_dot7: got vcnt=%0d code=%b len=%0d letter=%0d hit=%b expected 1 0000/1/4/1", vcnt, code, len, letter, hit);
    end
    clear_counts();
    hold(1'b1, 8);
    hold(1'b0, 16);
    checks++;
    if ({vcnt[3:0], code, len, letter, hit} !== {4'd1, 4'b1000, 3'd1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL thr_dash8: got vcnt=%0d code=%b len=%0d letter=%0d hit=%b expected 1 1000/1/0/0", vcnt, code, len, letter, hit);
    end
  endtask

  task automatic test_gap_boundary();
    clear_counts();
    hold(1'b1, 4);
    hold(1'b0, 11);
    hold(1'b1, 4);
    hold(1'b0, 16);
    checks++;
    if ({vcnt[3:0], code, len, letter, hit} !== {4'd1, 4'b0000, 3'd2, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL gap11_one_letter: got vcnt=%0d code=%b len=%0d letter=%0d hit=%b expected 1 0000/2/0/0", vcnt, code, len, letter, hit);
    end
    clear_counts();
    hold(1'b1, 4);
    hold(1'b0, 12);
    hold(1'b1, 4);
    hold(1'b0, 16);
    checks++;
    if (vcnt !== 2) begin errors++; $display("FAIL gap12_two_letters: got %0d expected 2", vcnt); end
    checks++;
    if ({code, len, letter, hit} !== {4'b0000, 3'd1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL gap12_E: got code=%b len=%0d letter=%0d hit=%b expected 0000/1/4/1", code, len, letter, hit);
    end
  endtask

  // Table-driven letters: code, len, expected letter index.
  task automatic test_letters();
    logic [3:0] tc [6] = '{4'b1000, 4'b1000, 4'b1010, 4'b0010, 4'b1100, 4'b0000};
    logic [2:0] tl [6] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd4};
    logic [2:0] te [6] = '{3'd3, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 6; k++) begin
      clear_counts();
      for (int s = 0; s < int'(tl[k]); s++) begin
        hold(1'b1, tc[k][3-s] ? 8 : 4);
        hold(1'b0, (s == int'(tl[k]) - 1) ? 16 : 4);
      end
      checks++;
      if ({vcnt[3:0], code, len, letter, hit} !== {4'd1, tc[k], tl[k], te[k], 1'b1}) begin
        errors++;
        $display("FAIL letter_%0d: got vcnt=%0d code=%b len=%0d letter=%0d hit=%b expected 1 %b/%0d/%0d/1",
                 k, vcnt, code, len, letter, hit, tc[k], tl[k], te[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_counts();
    hold(1'b1, 8);
    hold(1'b0, 4);
    hold(1'b1, 8);
    hold(1'b0, 4);
    reset_n = 1'b0;
    hold(1'b0, 3);
    reset_n = 1'b1;
    hold(1'b0, 40);
    checks++;
    if (vcnt !== 0 || ecnt !== 0) begin
      errors++;
      $display("FAIL midrst_pulses: got valid=%0d err=%0d expected 0 0", vcnt, ecnt);
    end
    checks++;
    if ({code, len, letter, hit, valid, err} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b expected 0", {code, len, letter, hit, valid, err});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc_tb = 0;
    v_cyc  = 0;
    vcnt   = 0;
    ecnt   = 0;
    reset_n = 1'b0;
    key = 1'b0;
    test_reset();
    test_letter_a();
    test_overflow();
    test_threshold();
    test_gap_boundary();
    test_letters();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Receive-side counterpart of the letter transmit path. Times presses of a single Morse key, classifies each as dot or dash, and assembles them into a 4-bit symbol code with a length, MSB-first, in the same code format the transmit shift register loads. Also decodes letters A–H. Sits between the debounced board key and the display logic.

## Interface
- UNIT_CYCLES, 25000000: clock cycles per Morse time unit (0.5 s at 50 MHz); minimum 2.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key  in  1  key level, 1 = pressed; asynchronous to clk and already debounced. The top level inverts the active-low board KEY.
- code  out  4  last letter's symbols, first symbol in bit 3, 1 = dash, unused low bits 0
- len  out  3  number of symbols in `code`, 1..4
- letter  out  3  decoded letter index, A=0 … H=7
- hit  out  1  `code`/`len` matches one of A–H
- valid  out  1  one-cycle pulse; `code`/`len`/`letter`/`hit` updated this cycle
- err  out  1  one-cycle pulse; letter had more than 4 symbols

## Operation
- Synchronizer: `key` passes through 2 flops (reset 0) to give key_s. A key held high through reset release is seen as a press.
- Timebase:
  - cyc counter counts 0..UNIT_CYCLES-1.
  - At the wrap, the units counter increments, saturating at 7.
  - Both counters clear on every key_s edge.
- FSM states IDLE, PRESS, GAP:
  - IDLE: key_s rising goes to PRESS. The symbol shift register sr[3:0] and count n are already 0.
  - PRESS: key_s falling goes to GAP and classifies the press.
    - units < 2 is a dot (0); units >= 2 is a dash (1). A saturated long press is a dash.
    - If n < 4: write the symbol into sr[3-n] and increment n.
    - If n == 4: set the overflow flag and leave sr unchanged.
  - GAP: key_s rising before units reaches 3 goes to PRESS (next symbol of the same letter).
  - GAP: units reaching 3 ends the letter and goes to IDLE, clearing sr, n and overflow.
- Letter end:
  - overflow = 0: code <= sr, len <= n, letter/hit from the table, valid = 1.
  - overflow = 1: err = 1, and code/len/letter/hit hold their previous values.
- Decode table, code/len:
  - A 0100/2, B 1000/4, C 1010/4, D 1000/3
  - E 0000/1, F 0010/4, G 1100/3, H 0000/4
  - No match gives hit = 0 and letter = 0.
- Reset values: code, len, letter, hit, valid, err all 0; FSM in IDLE; counters 0.
- Reset mid-letter: the partial letter is discarded and no pulse is produced.

## Timing
- key_s lags key by 2 clk edges.
- Press classification is registered on the clk edge where the falling edge of key_s is first seen.
- valid/err are registered outputs. They are high for exactly one cycle: the cycle after units becomes 3 in GAP, i.e. 3*UNIT_CYCLES+1 cycles after the falling edge of key_s.
- Dot/dash boundary: a press of 2*UNIT_CYCLES-1 cycles of key_s high is a dot; 2*UNIT_CYCLES cycles is a dash.
- Gap boundary:
  - A rising edge of key_s at gap cycle 3*UNIT_CYCLES-1 continues the letter.
  - Once units reaches 3, the letter is ended. A press on that same cycle starts a new letter from PRESS; the end pulse still fires.
- Outputs other than the pulses are stable between pulses.

## Test plan
- UNIT_CYCLES=4 for all runs.
- Reset: reset_n low with key=1, then release.
  - All outputs are 0 during reset.
  - After release, the key is seen as a press, and an E decodes after the key drops.
- A: press 4, release 4, press 12, release 16.
  - valid pulse once; code=0100, len=2, letter=0, hit=1.
- Threshold: press 7 cycles, then a separate letter with press 8 cycles, gap 16 each.
  - First letter: E (code 0000, len 1).
  - Second letter: code 1000, len 1, hit=0, letter=0.
- Gap boundary: dot, gap of 11 cycles, dot, gap 16.
  - Result is one letter, code 0000, len 2, hit=0.
  - Repeating with a 12-cycle gap gives two E pulses.
- Overflow: five dots with 4-cycle gaps, then gap 16.
  - err pulses once, valid stays 0.
  - code/len keep the prior letter.
- Reset mid-letter: two dashes, reset_n pulse low during the gap, then idle for 40 cycles.
  - No valid or err pulse.
  - All outputs remain 0.
